// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator op sequencer.
// The divider (op 6) is built only when CALC_DIV_EN is defined.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_RSV = 3'd7
    } calc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } calc_state_e;

    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_Z = 3;

    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shift-add multiplier and restoring divider sharing one {acc, mq} shift pair.
// The divider half exists only when CALC_DIV_EN is defined.
module calc_iter_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start,
    input  logic             div_sel,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_lo,
    output logic [WIDTH-1:0] next_hi
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;

    // Multiplier: mq holds the unconsumed multiplier bits, product shifts in from the top.
    always_comb begin
        mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], mq[WIDTH-1:1]};
    end

`ifdef CALC_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_hi;

    // Divider: acc is the partial remainder, mq shifts dividend out and quotient in.
    always_comb begin
        div_shift = {acc, mq[WIDTH-1]};
        div_fit   = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift - {1'b0, opnd};
        if (div_fit) begin
            div_hi = div_diff[WIDTH-1:0];
            div_lo = {mq[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = div_shift[WIDTH-1:0];
            div_lo = {mq[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            div_q <= 1'b0;
        else if (start)
            div_q <= div_sel;
    end

    assign next_lo = div_q ? div_lo : mul_lo;
    assign next_hi = div_q ? div_hi : mul_hi;
`else
    assign next_lo = mul_lo;
    assign next_hi = mul_hi;
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            acc  <= '0;
            mq   <= '0;
            opnd <= '0;
        end else if (start) begin
            acc  <= '0;
            mq   <= div_sel ? a : b;
            opnd <= div_sel ? b : a;
        end else if (step) begin
            acc  <= next_hi;
            mq   <= next_lo;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator arithmetic sequencer: single-cycle ALU ops plus iterative MUL/DIV.
// Define CALC_DIV_EN to build the divider; otherwise op 6 behaves as reserved op 7.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// req_ready is high only in IDLE; res_valid is high only in DONE and stays high,
// with result/flag_in stable, until res_ready is seen.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_w,
    output logic [3:0]       flag_in,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    calc_state_e      state, next_state;
    calc_op_e         op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    count;
    logic             accept, iter_go, last_step;
    logic [WIDTH-1:0] it_lo, it_hi;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff, exec_res;
    logic             exec_c, exec_v, illegal, hi_nz;
    logic [3:0]       exec_flg, iter_flg;

    assign accept    = (state == IDLE) && req_valid;
    assign last_step = (state == ITER) && (count == CW'(1));

`ifdef CALC_DIV_EN
    // Divide by zero skips iteration and is answered by the EXEC path.
    assign iter_go = (calc_op_e'(op) == OP_MUL) || ((calc_op_e'(op) == OP_DIV) && (b != '0));
`else
    assign iter_go = (calc_op_e'(op) == OP_MUL);
`endif

    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .RESET   (RESET),
        .start   (accept && iter_go),
        .div_sel (calc_op_e'(op) == OP_DIV),
        .step    (state == ITER),
        .a       (a),
        .b       (b),
        .next_lo (it_lo),
        .next_hi (it_hi)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = iter_go ? ITER : EXEC;
            EXEC:    next_state = DONE;
            ITER:    if (count == CW'(1)) next_state = DONE;
            DONE:    if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = a_q - b_q;
        exec_res = '0;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        illegal  = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_res = sum[WIDTH-1:0];
                exec_c   = sum[WIDTH];
                exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = diff;
                exec_c   = (a_q < b_q);
                exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
`ifdef CALC_DIV_EN
            OP_DIV: begin
                exec_res = '1;
                exec_v   = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
        exec_flg = illegal ? 4'b0001
                           : pack_flags(exec_v, exec_c, exec_res[WIDTH-1], exec_res == '0);
        hi_nz    = (op_q == OP_MUL) && (it_hi != '0);
        iter_flg = pack_flags(hi_nz, hi_nz, it_lo[WIDTH-1], it_lo == '0);
    end

    // result/flag_in load only on entry to DONE, so they hold through backpressure.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            count   <= '0;
            result  <= '0;
            flag_in <= '0;
            flag_w  <= 1'b0;
        end else begin
            flag_w <= 1'b0;
            if (accept) begin
                op_q  <= calc_op_e'(op);
                a_q   <= a;
                b_q   <= b;
                count <= CW'(WIDTH);
            end
            if (state == ITER)
                count <= count - CW'(1);
            if (state == EXEC) begin
                result  <= exec_res;
                flag_in <= exec_flg;
                flag_w  <= 1'b1;
            end
            if (last_step) begin
                result  <= it_lo;
                flag_in <= iter_flg;
                flag_w  <= 1'b1;
            end
        end
    end

endmodule
